// File: rtl/led_scan_driver.sv
// Row-scanned LED matrix driver: fetches a 32-bit row, shifts it out MSB first, latches it and
// advances the row decoder. Define LED_SCAN_BLANK_EN to insert a 4-cycle blanking gap before LATCH.
module led_scan_driver #(
  parameter int NROWS = 20,
  parameter int DIV   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [31:0] RowData,
  output logic [4:0]  RowAddr,
  output logic        SCLK,
  output logic        SDO,
  output logic        LATCH,
  output logic [4:0]  RowDrv,
  output logic        OE_N,
  output logic        FrameDone
);

`ifdef LED_SCAN_BLANK_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_BLANK = 3'd3,
    S_LATCH = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_LATCH = 3'd4
  } state_t;
`endif

  localparam logic [3:0] DIV_LAST = 4'(DIV - 1);
  localparam logic [4:0] ROW_LAST = 5'(NROWS - 1);

  state_t      state_r;
  logic [31:0] shreg_r;
  logic [3:0]  div_cnt_r;
  logic [4:0]  bit_cnt_r;
  logic        sclk_r;
  logic        latch_r;
  logic        oe_n_r;
  logic [4:0]  row_addr_r;
  logic [4:0]  row_drv_r;
  logic        frame_done_r;
`ifdef LED_SCAN_BLANK_EN
  logic [1:0]  blank_cnt_r;
`endif

  logic        div_wrap_s;
  logic        last_row_s;
  logic [4:0]  row_addr_next_s;

  assign div_wrap_s      = (div_cnt_r == DIV_LAST);
  assign last_row_s      = (row_addr_r == ROW_LAST);
  assign row_addr_next_s = last_row_s ? 5'd0 : (row_addr_r + 5'd1);

  // Scan sequencer: state, serialiser, row counters and all registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r      <= S_IDLE;
      shreg_r      <= 32'd0;
      div_cnt_r    <= 4'd0;
      bit_cnt_r    <= 5'd0;
      sclk_r       <= 1'b0;
      latch_r      <= 1'b0;
      oe_n_r       <= 1'b1;
      row_addr_r   <= 5'd0;
      row_drv_r    <= 5'd0;
      frame_done_r <= 1'b0;
`ifdef LED_SCAN_BLANK_EN
      blank_cnt_r  <= 2'd0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (EN) state_r <= S_LOAD;
          else    state_r <= S_IDLE;
        end
        S_LOAD: begin
          shreg_r   <= RowData;
          div_cnt_r <= 4'd0;
          bit_cnt_r <= 5'd0;
          sclk_r    <= 1'b0;
          state_r   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (!div_wrap_s) begin
            div_cnt_r <= div_cnt_r + 4'd1;
          end else begin
            div_cnt_r <= 4'd0;
            if (!sclk_r) begin
              sclk_r <= 1'b1;
            end else begin
              // Falling SCLK edge: the only point where the data bit may advance
              sclk_r <= 1'b0;
              if (bit_cnt_r == 5'd31) begin
`ifdef LED_SCAN_BLANK_EN
                state_r     <= S_BLANK;
                blank_cnt_r <= 2'd0;
                oe_n_r      <= 1'b1;
`else
                state_r      <= S_LATCH;
                latch_r      <= 1'b1;
                oe_n_r       <= 1'b1;
                row_drv_r    <= row_addr_r;
                row_addr_r   <= row_addr_next_s;
                frame_done_r <= last_row_s;
`endif
              end else begin
                bit_cnt_r <= bit_cnt_r + 5'd1;
                shreg_r   <= {shreg_r[30:0], 1'b0};
              end
            end
          end
        end
`ifdef LED_SCAN_BLANK_EN
        S_BLANK: begin
          if (blank_cnt_r == 2'd3) begin
            state_r      <= S_LATCH;
            latch_r      <= 1'b1;
            oe_n_r       <= 1'b1;
            row_drv_r    <= row_addr_r;
            row_addr_r   <= row_addr_next_s;
            frame_done_r <= last_row_s;
          end else begin
            blank_cnt_r <= blank_cnt_r + 2'd1;
          end
        end
`endif
        S_LATCH: begin
          latch_r      <= 1'b0;
          frame_done_r <= 1'b0;
          oe_n_r       <= 1'b0;
          if (EN) state_r <= S_LOAD;
          else    state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign RowAddr   = row_addr_r;
  assign SCLK      = sclk_r;
  assign SDO       = shreg_r[31];
  assign LATCH     = latch_r;
  assign RowDrv    = row_drv_r;
  assign OE_N      = oe_n_r;
  assign FrameDone = frame_done_r;

endmodule

// File: tb/tb_led_scan_driver.sv
// Self-checking bench for led_scan_driver: row expectations are queued as stimulus is set up and
// compared against records captured by a negedge monitor at each LATCH pulse.
module tb_led_scan_driver;
  localparam int NROWS = 20;
  localparam int DIV   = 2;
`ifdef LED_SCAN_BLANK_EN
  localparam int ROW_PERIOD = 6 + 64 * DIV;
  localparam int OE_HI      = 5;
`else
  localparam int ROW_PERIOD = 2 + 64 * DIV;
  localparam int OE_HI      = 1;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic [31:0] RowData;
  logic [4:0]  RowAddr;
  logic        SCLK;
  logic        SDO;
  logic        LATCH;
  logic [4:0]  RowDrv;
  logic        OE_N;
  logic        FrameDone;

  logic [31:0] bank [0:31];
  logic        rd_override;
  logic [31:0] rd_val;
  assign RowData = rd_override ? rd_val : bank[RowAddr];

  led_scan_driver #(.NROWS(NROWS), .DIV(DIV)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .RowData(RowData), .RowAddr(RowAddr), .SCLK(SCLK),
    .SDO(SDO), .LATCH(LATCH), .RowDrv(RowDrv), .OE_N(OE_N), .FrameDone(FrameDone)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  drv;
    logic [4:0]  addr;
    logic        fd;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    int          nbits;
    logic [4:0]  drv;
    logic [4:0]  addr;
    logic        fd;
    int          cyc;
    int          oe_hi;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  int   obs_rd = 0;

  logic [31:0] cap;
  int          ncap = 0;
  int          oe_cnt = 0;
  int          sdo_viol = 0;
  int          fd_cnt = 0;
  int          fd_stray = 0;
  logic        sclk_q = 1'b0;
  logic        sdo_q = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: collect SDO on SCLK rising edges and emit one record per LATCH pulse
  always @(negedge CLK) begin
    if (!RST) begin
      cap = 32'd0; ncap = 0; oe_cnt = 0; sclk_q = 1'b0; sdo_q = 1'b0;
    end else begin
      if (SCLK && !sclk_q) begin
        cap = {cap[30:0], SDO};
        ncap++;
      end else if (SCLK && sclk_q && (SDO !== sdo_q)) begin
        sdo_viol++;
      end
      if (OE_N) oe_cnt++;
      if (FrameDone) fd_cnt++;
      if (FrameDone && !LATCH) fd_stray++;
      if (LATCH) begin
        obs_q.push_back('{cap, ncap, RowDrv, RowAddr, FrameDone, cyc, oe_cnt});
        cap = 32'd0; ncap = 0; oe_cnt = 0;
      end
      sclk_q = SCLK;
      sdo_q  = SDO;
    end
  end

  task automatic wait_obs(output obs_t o, output bit ok);
    ok = 1'b0;
    o  = '{32'd0, 0, 5'd0, 5'd0, 1'b0, 0, 0};
    for (int i = 0; i < 600; i++) begin
      if (obs_rd < obs_q.size()) begin
        o = obs_q[obs_rd];
        obs_rd++;
        ok = 1'b1;
        break;
      end
      @(negedge CLK); #1;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL latch_timeout: no LATCH within 600 cycles, required one");
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; EN = 1'b0; rd_override = 1'b0; rd_val = 32'd0;
    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if ({SCLK, SDO, LATCH, OE_N, FrameDone} !== 5'b00010) begin
      failures++; $display("FAIL reset_ctrl: got %b required 00010", {SCLK, SDO, LATCH, OE_N, FrameDone});
    end
    checks++;
    if (RowAddr !== 5'd0) begin failures++; $display("FAIL reset_rowaddr: got %0d required 0", RowAddr); end
    checks++;
    if (RowDrv !== 5'd0) begin failures++; $display("FAIL reset_rowdrv: got %0d required 0", RowDrv); end
  endtask

  task automatic test_first_row(output int latch_cyc);
    obs_t o; exp_t e; bit ok; int t0;
    latch_cyc = 0;
    RST = 1'b1; EN = 1'b1; t0 = cyc;
    exp_q.push_back('{32'h8000_0001, 5'd0, 5'd1, 1'b0});
    repeat (60) @(negedge CLK);
    #1;
    checks++;
    if (OE_N !== 1'b1) begin failures++; $display("FAIL oe_before_first_latch: got %b required 1", OE_N); end
    wait_obs(o, ok);
    if (ok) begin
      e = exp_q.pop_front();
      latch_cyc = o.cyc;
      checks++;
      if (o.data !== e.data || o.nbits != 32) begin
        failures++; $display("FAIL first_row_bits: got %h/%0d required %h/32", o.data, o.nbits, e.data);
      end
      checks++;
      if (o.drv !== e.drv || o.addr !== e.addr || o.fd !== e.fd) begin
        failures++; $display("FAIL first_row_regs: got drv=%0d addr=%0d fd=%b required drv=%0d addr=%0d fd=%b",
                             o.drv, o.addr, o.fd, e.drv, e.addr, e.fd);
      end
      checks++;
      if (o.cyc - t0 != ROW_PERIOD) begin
        failures++; $display("FAIL first_row_latency: got %0d required %0d", o.cyc - t0, ROW_PERIOD);
      end
      @(negedge CLK); #1;
      checks++;
      if (OE_N !== 1'b0) begin failures++; $display("FAIL oe_after_latch: got %b required 0", OE_N); end
    end
  endtask

  task automatic test_frame(input int first_cyc, output int last_cyc);
    obs_t o; exp_t e; bit ok; int prev; int fd0;
    prev = first_cyc; fd0 = fd_cnt; last_cyc = first_cyc;
    for (int r = 1; r <= NROWS; r++) begin
      int rr;
      rr = r % NROWS;
      exp_q.push_back('{bank[rr], 5'(rr), 5'((rr + 1) % NROWS), (rr == NROWS - 1)});
    end
    for (int r = 1; r <= NROWS; r++) begin
      wait_obs(o, ok);
      if (!ok) break;
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.nbits != 32) begin
        failures++; $display("FAIL frame_bits row %0d: got %h/%0d required %h/32", e.drv, o.data, o.nbits, e.data);
      end
      checks++;
      if (o.drv !== e.drv || o.addr !== e.addr || o.fd !== e.fd) begin
        failures++; $display("FAIL frame_regs: got drv=%0d addr=%0d fd=%b required drv=%0d addr=%0d fd=%b",
                             o.drv, o.addr, o.fd, e.drv, e.addr, e.fd);
      end
      checks++;
      if (o.cyc - prev != ROW_PERIOD || o.oe_hi != OE_HI) begin
        failures++; $display("FAIL frame_timing row %0d: got period=%0d oe_hi=%0d required %0d/%0d",
                             e.drv, o.cyc - prev, o.oe_hi, ROW_PERIOD, OE_HI);
      end
      prev = o.cyc;
    end
    last_cyc = prev;
    exp_q.delete();
    checks++;
    if (fd_cnt - fd0 != 1) begin failures++; $display("FAIL frame_done_count: got %0d required 1", fd_cnt - fd0); end
    checks++;
    if (last_cyc - first_cyc != NROWS * ROW_PERIOD) begin
      failures++; $display("FAIL frame_length: got %0d required %0d", last_cyc - first_cyc, NROWS * ROW_PERIOD);
    end
  endtask

  task automatic test_en_drop();
    obs_t o; exp_t e; bit ok; bit found; int prev; int t0;
    found = 1'b0; prev = 0;
    for (int k = 0; k < 4 && !found; k++) begin
      wait_obs(o, ok);
      if (ok && o.drv == 5'd2) begin found = 1'b1; prev = o.cyc; end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL en_drop_sync: got no row 2 latch required one"); return; end
    exp_q.push_back('{bank[3], 5'd3, 5'd4, 1'b0});
    repeat (2 + 10 * 2 * DIV) @(negedge CLK);
    #1; EN = 1'b0;
    wait_obs(o, ok);
    if (ok) begin
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.drv !== e.drv || o.addr !== e.addr || o.cyc - prev != ROW_PERIOD) begin
        failures++; $display("FAIL en_drop_row: got %h drv=%0d addr=%0d period=%0d required %h drv=3 addr=4 period=%0d",
                             o.data, o.drv, o.addr, o.cyc - prev, e.data, ROW_PERIOD);
      end
    end
    repeat (20) @(negedge CLK);
    #1;
    checks++;
    if (obs_rd != obs_q.size()) begin failures++; $display("FAIL idle_no_latch: got %0d extra latches required 0", obs_q.size() - obs_rd); end
    checks++;
    if ({OE_N, LATCH, SCLK} !== 3'b000 || RowDrv !== 5'd3 || RowAddr !== 5'd4) begin
      failures++; $display("FAIL idle_state: got oe_n=%b latch=%b sclk=%b drv=%0d addr=%0d required 0 0 0 3 4",
                           OE_N, LATCH, SCLK, RowDrv, RowAddr);
    end
    EN = 1'b1; t0 = cyc;
    exp_q.push_back('{bank[4], 5'd4, 5'd5, 1'b0});
    wait_obs(o, ok);
    if (ok) begin
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.drv !== e.drv || o.addr !== e.addr || o.cyc - t0 != ROW_PERIOD) begin
        failures++; $display("FAIL resume_row: got %h drv=%0d addr=%0d lat=%0d required %h drv=4 addr=5 lat=%0d",
                             o.data, o.drv, o.addr, o.cyc - t0, e.data, ROW_PERIOD);
      end
    end
  endtask

  task automatic test_reset_mid_row();
    obs_t o; exp_t e; bit ok; int t0;
    repeat (2 + 20 * 2 * DIV) @(negedge CLK);
    #3; RST = 1'b0; #1;
    checks++;
    if ({SCLK, SDO, LATCH, OE_N, FrameDone, RowAddr, RowDrv} !== {5'b00010, 5'd0, 5'd0}) begin
      failures++; $display("FAIL async_reset: got %b required %b",
                           {SCLK, SDO, LATCH, OE_N, FrameDone, RowAddr, RowDrv}, {5'b00010, 5'd0, 5'd0});
    end
    repeat (5) @(negedge CLK);
    #1;
    checks++;
    if (obs_rd != obs_q.size()) begin failures++; $display("FAIL reset_no_latch: got %0d latches required 0", obs_q.size() - obs_rd); end
    RST = 1'b1; t0 = cyc;
    exp_q.push_back('{bank[0], 5'd0, 5'd1, 1'b0});
    repeat (50) @(negedge CLK);
    #1;
    checks++;
    if (OE_N !== 1'b1) begin failures++; $display("FAIL oe_after_reset: got %b required 1", OE_N); end
    wait_obs(o, ok);
    if (ok) begin
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.drv !== e.drv || o.addr !== e.addr || o.cyc - t0 != ROW_PERIOD) begin
        failures++; $display("FAIL restart_row: got %h drv=%0d addr=%0d lat=%0d required %h drv=0 addr=1 lat=%0d",
                             o.data, o.drv, o.addr, o.cyc - t0, e.data, ROW_PERIOD);
      end
    end
  endtask

  task automatic test_rowdata_toggle();
    obs_t o; exp_t e; bit ok;
    @(negedge CLK);
    exp_q.push_back('{32'hFFFF_0000, 5'd1, 5'd2, 1'b0});
    rd_val = 32'h5A5A_A5A5;
    for (int i = 0; i < 64 * DIV; i++) begin
      @(negedge CLK);
      rd_override = 1'b1;
      rd_val = ~rd_val;
    end
    @(negedge CLK);
    rd_override = 1'b0;
    wait_obs(o, ok);
    if (ok) begin
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.nbits != 32 || o.drv !== e.drv) begin
        failures++; $display("FAIL toggle_isolation: got %h/%0d drv=%0d required %h/32 drv=1", o.data, o.nbits, o.drv, e.data);
      end
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (sdo_viol != 0) begin failures++; $display("FAIL sdo_stable: got %0d changes while SCLK high required 0", sdo_viol); end
    checks++;
    if (fd_stray != 0) begin failures++; $display("FAIL framedone_align: got %0d stray pulses required 0", fd_stray); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1;
    for (int i = 0; i < 32; i++) bank[i] = $urandom();
    bank[0] = 32'h8000_0001;
    bank[1] = 32'hFFFF_0000;
    test_reset();
    test_first_row(c0);
    test_frame(c0, c1);
    test_en_drop();
    test_reset_mid_row();
    test_rowdata_toggle();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_scan_driver.md
LED_SCAN_DRIVER -- requirements
Module: led_scan_driver

Interface
REQ-001 Parameter NROWS, default 20: number of display rows scanned per frame (range 2..32).
REQ-002 Parameter DIV, default 2: CLK cycles per SCLK half-period (range 1..16).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 EN  input  1  scan enable; low parks the block in IDLE at the next row boundary.
REQ-006 RowData  input  32  column bits of the row selected by RowAddr; bit 31 is the leftmost column; sourced from the row-register bank.
REQ-007 RowAddr  output  5  row index currently being fetched from the row-register bank.
REQ-008 SCLK  output  1  serial shift clock to the external column shift-register chain.
REQ-009 SDO  output  1  serial column data, MSB (bit 31) first.
REQ-010 LATCH  output  1  one-cycle pulse that transfers the shifted row to the column drivers.
REQ-011 RowDrv  output  5  row index currently displayed; feeds the row decoder.
REQ-012 OE_N  output  1  active-low display output enable.
REQ-013 FrameDone  output  1  one-cycle pulse when the last row (NROWS-1) is latched.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, SHIFT, BLANK (macro only) and LATCH.
REQ-015 IDLE SHALL move to LOAD on the first CLK edge with EN=1, and SHALL otherwise hold.
REQ-016 LOAD SHALL last one cycle, capture RowData into a 32-bit shift register, then go to SHIFT.
REQ-017 SHIFT SHALL emit 32 bits; per bit, SDO is valid with SCLK=0 for DIV cycles, then SCLK=1 for DIV cycles; SHIFT lasts exactly 64*DIV cycles.
REQ-018 SDO SHALL change only while SCLK=0; the first bit is RowData[31] captured in LOAD.
REQ-019 After the 32nd bit, SCLK SHALL return to 0 and the FSM SHALL go to BLANK (macro on) or LATCH (macro off).
REQ-020 In the LATCH cycle: LATCH=1; OE_N=1; RowDrv loads the current RowAddr; RowAddr increments, wrapping from NROWS-1 to 0.
REQ-021 FrameDone SHALL pulse in the same cycle as LATCH when RowDrv is loaded with NROWS-1.
REQ-022 After LATCH: go to LOAD if EN=1, else go to IDLE; OE_N SHALL be 0 in every cycle outside LATCH/BLANK once the first row has been latched.
REQ-023 EN deasserted mid-row SHALL NOT abort the row; the row completes through LATCH, then the FSM goes to IDLE with OE_N held 0 (last row stays lit).
REQ-024 Changes on RowData outside the LOAD cycle SHALL have no effect on the row being shifted.
REQ-025 Row period with EN held high SHALL be 2+64*DIV cycles (macro off), i.e. 130 at DIV=2.

Reset
REQ-026 While RST=0: FSM=IDLE, SCLK=0, SDO=0, LATCH=0, OE_N=1, RowAddr=0, RowDrv=0, FrameDone=0, shift register=0.
REQ-027 RST asserted mid-row SHALL abort immediately, with no LATCH pulse; after release, the scan restarts at row 0.
REQ-028 OE_N SHALL stay 1 after reset until the first LATCH completes.

Configuration
REQ-029 Macro LED_SCAN_BLANK_EN defined: a BLANK state of exactly 4 cycles SHALL be inserted between SHIFT and LATCH, with OE_N=1 through BLANK and LATCH; row period = 6+64*DIV (134 at DIV=2).
REQ-030 Macro LED_SCAN_BLANK_EN undefined: there SHALL be no BLANK state, and OE_N=1 only in the LATCH cycle.

Verification
REQ-031 Reset, then EN=1 with RowData=32'h8000_0001 for row 0 -> SDO sequence 1,0x30,1 sampled on SCLK rising edges; LATCH at cycle 130 after LOAD start; RowDrv=0; RowAddr=1.
REQ-032 NROWS=20, EN held high for 20 rows -> RowAddr sequence 0..19,0; FrameDone pulses exactly once, coincident with the LATCH for row 19; frame = 2600 cycles at DIV=2.
REQ-033 EN dropped at bit 10 of row 3 -> row 3 shifts fully, LATCH pulses, FSM reaches IDLE, OE_N=0, RowDrv=3; EN re-raised -> scan resumes at row 4.
REQ-034 RST pulsed low at bit 20 of row 5 -> all outputs reach reset values asynchronously, with no LATCH pulse; after release and EN=1, first LOAD fetches row 0.
REQ-035 RowData toggled every cycle during SHIFT with 32'hFFFF_0000 captured in LOAD -> shifted bits are 16 ones then 16 zeros.
REQ-036 LED_SCAN_BLANK_EN defined, DIV=1 -> OE_N high for 5 consecutive cycles per row; row period 70 cycles.
